// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD-over-SPI register file and data buffers:
// register indices, STATUS/IRQ bit positions and the SD idle fill byte.
package sd_spi_pkg;

    // Word indices, taken from paddr[4:2]
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_ADDR     = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_DATA     = 3'd3;
    localparam logic [2:0] REG_RXCNT    = 3'd4;
    localparam logic [2:0] REG_TXCNT    = 3'd5;
    localparam logic [2:0] REG_IRQ_EN   = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    // STATUS read bits
    localparam int ST_BUSY     = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_TX_EMPTY = 3;
    localparam int ST_TX_FULL  = 4;

    // STATUS write bits
    localparam int ST_FLUSH_RX = 0;
    localparam int ST_FLUSH_TX = 1;

    // IRQ_EN / IRQ_STAT bits
    localparam int IRQ_DONE   = 0;
    localparam int IRQ_RX_OVF = 1;
    localparam int IRQ_TX_UNF = 2;
    localparam int IRQ_TX_OVF = 3;
    localparam int IRQ_W      = 4;

    // Byte the SD card sees when software has nothing queued
    localparam logic [7:0] SD_FILL = 8'hFF;

endpackage

// File: rtl/sd_spi_regbuf_if.sv
// APB slave bus between the bus fabric (master) and the register file (slave).
interface sd_spi_regbuf_if #(
    parameter int REG_W = 16
);
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [4:0]       paddr;
    logic [REG_W-1:0] pwdata;
    logic [REG_W-1:0] prdata;
    logic             pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/sd_fifo.sv
// Pointer-based circular FIFO with show-ahead head, occupancy count and
// overflow/underflow strobes. An empty FIFO presents the SD idle fill byte.
module sd_fifo
    import sd_spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 512,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));

    // A pop on a full FIFO frees the slot the same-cycle push lands in;
    // a pop on an empty FIFO is ignored. Flush overrides both.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign ovf     = push & full & ~pop & ~flush;
    assign unf     = pop & empty & ~flush;

    assign count = cnt;
    assign dout  = empty ? DATA_W'(SD_FILL) : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // validity, and leaving the array reset-free lets it map onto RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sd_spi_regbuf.sv
// APB register file and RX/TX data buffers between the APB port and the SD
// command/transfer controller, with sticky maskable interrupt status.
module sd_spi_regbuf
    import sd_spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int REG_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sd_spi_regbuf_if.slave    apb,
    input  logic              busy_i,
    input  logic              ctrl_clr_i,
    input  logic              rx_enq_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              tx_deq_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [REG_W-1:0]  ctrl_o,
    output logic [REG_W-1:0]  addr_o,
    output logic              irq_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [REG_W-1:0]  ctrl;
    logic [REG_W-1:0]  addr;
    logic [IRQ_W-1:0]  irq_en;
    logic [IRQ_W-1:0]  irq_stat;
    logic [IRQ_W-1:0]  irq_set;
    logic [IRQ_W-1:0]  irq_clr;
    logic              busy_q;

    logic              wr_acc;
    logic              rd_acc;
    logic [2:0]        idx;
    logic [REG_W-1:0]  rdata;

    logic              rx_pop;
    logic              rx_flush;
    logic [DATA_W-1:0] rx_dout;
    logic [CNT_W-1:0]  rx_count;
    logic              rx_empty;
    logic              rx_full;
    logic              rx_ovf;

    logic              tx_push;
    logic              tx_flush;
    logic [DATA_W-1:0] tx_dout;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_empty;
    logic              tx_full;
    logic              tx_ovf;
    logic              tx_unf;

    logic              unused_bits;

    // Zero-wait-state APB: every access completes in its enable cycle
    assign wr_acc = apb.psel & apb.penable & apb.pwrite;
    assign rd_acc = apb.psel & apb.penable & ~apb.pwrite;
    assign idx    = apb.paddr[4:2];
    assign apb.pready = 1'b1;

    assign rx_pop   = rd_acc && (idx == REG_DATA);
    assign tx_push  = wr_acc && (idx == REG_DATA);
    assign rx_flush = wr_acc && (idx == REG_STATUS) && apb.pwdata[ST_FLUSH_RX];
    assign tx_flush = wr_acc && (idx == REG_STATUS) && apb.pwdata[ST_FLUSH_TX];

    sd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (rx_enq_i),
        .pop    (rx_pop),
        .flush  (rx_flush),
        .din    (rx_data_i),
        .dout   (rx_dout),
        .count  (rx_count),
        .empty  (rx_empty),
        .full   (rx_full),
        .ovf    (rx_ovf),
        .unf    (unused_bits)
    );

    sd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (tx_push),
        .pop    (tx_deq_i),
        .flush  (tx_flush),
        .din    (apb.pwdata[DATA_W-1:0]),
        .dout   (tx_dout),
        .count  (tx_count),
        .empty  (tx_empty),
        .full   (tx_full),
        .ovf    (tx_ovf),
        .unf    (tx_unf)
    );

    // An RX read on empty is swallowed by the FIFO, so its underflow strobe
    // carries no information; fold it with the ignored byte-lane address bits.
    logic unused_addr;
    assign unused_addr = ^{unused_bits, apb.paddr[1:0]};

    always_comb begin
        irq_set             = '0;
        irq_set[IRQ_DONE]   = busy_q & ~busy_i;
        irq_set[IRQ_RX_OVF] = rx_ovf;
        irq_set[IRQ_TX_UNF] = tx_unf;
        irq_set[IRQ_TX_OVF] = tx_ovf;
    end

    assign irq_clr = (wr_acc && (idx == REG_IRQ_STAT)) ? apb.pwdata[IRQ_W-1:0] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl     <= '0;
            addr     <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            busy_q   <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            // Software write wins over the controller's clear
            if (wr_acc && (idx == REG_CTRL))  ctrl <= apb.pwdata;
            else if (ctrl_clr_i)              ctrl <= '0;
            if (wr_acc && (idx == REG_ADDR))  addr <= apb.pwdata;
            if (wr_acc && (idx == REG_IRQ_EN)) irq_en <= apb.pwdata[IRQ_W-1:0];
            // Set is applied after clear so a coincident event is not lost
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            busy_q   <= busy_i;
            irq_o    <= |(irq_stat & irq_en);
        end
    end

    // NOTE: rdata is defaulted before the case so every path assigns it and
    // no latch is inferred.
    always_comb begin
        rdata = '0;
        if (rd_acc) begin
            case (idx)
                REG_CTRL:     rdata = ctrl;
                REG_ADDR:     rdata = addr;
                REG_STATUS: begin
                    rdata[ST_BUSY]     = busy_i;
                    rdata[ST_RX_EMPTY] = rx_empty;
                    rdata[ST_RX_FULL]  = rx_full;
                    rdata[ST_TX_EMPTY] = tx_empty;
                    rdata[ST_TX_FULL]  = tx_full;
                end
                REG_DATA:     rdata = REG_W'(rx_dout);
                REG_RXCNT:    rdata = REG_W'(rx_count);
                REG_TXCNT:    rdata = REG_W'(tx_count);
                REG_IRQ_EN:   rdata = REG_W'(irq_en);
                REG_IRQ_STAT: rdata = REG_W'(irq_stat);
                default:      rdata = '0;
            endcase
        end
    end

    assign apb.prdata = rdata;
    assign tx_data_o  = tx_dout;
    assign ctrl_o     = ctrl;
    assign addr_o     = addr;

endmodule

// File: tb/tb_sd_spi_regbuf.sv
// Scoreboard bench for sd_spi_regbuf: stimulus queues expected responses,
// a negedge monitor pops and compares whenever the DUT presents data.
module tb_sd_spi_regbuf;
    import sd_spi_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;
    localparam int REG_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              busy;
    logic              ctrl_clr;
    logic              rx_enq;
    logic [DATA_W-1:0] rx_data;
    logic              tx_deq;
    logic [DATA_W-1:0] tx_data;
    logic [REG_W-1:0]  ctrl;
    logic [REG_W-1:0]  addr;
    logic              irq;

    always #5 clk = ~clk;

    sd_spi_regbuf_if #(.REG_W(REG_W)) apb ();

    sd_spi_regbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REG_W  (REG_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .apb        (apb),
        .busy_i     (busy),
        .ctrl_clr_i (ctrl_clr),
        .rx_enq_i   (rx_enq),
        .rx_data_i  (rx_data),
        .tx_deq_i   (tx_deq),
        .tx_data_o  (tx_data),
        .ctrl_o     (ctrl),
        .addr_o     (addr),
        .irq_o      (irq)
    );

    typedef enum {OBS_CTRL, OBS_ADDR, OBS_IRQ, OBS_TX} obs_e;
    typedef struct {
        string        name;
        obs_e         sel;
        logic [15:0]  val;
    } exp_t;

    exp_t rd_q[$];
    exp_t tx_q[$];
    exp_t obs_q[$];
    logic obs_probe = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents this cycle against the queues
    always @(negedge clk) begin
        exp_t e;
        if (apb.psel && apb.penable && !apb.pwrite) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got read 0x%04h expected none", apb.prdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, apb.prdata, e.val);
            end
        end
        if (tx_deq) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%02h expected none", tx_data);
            end else begin
                e = tx_q.pop_front();
                check(e.name, {8'h00, tx_data}, e.val);
            end
        end
        if (obs_probe && obs_q.size() != 0) begin
            e = obs_q.pop_front();
            case (e.sel)
                OBS_CTRL: check(e.name, ctrl, e.val);
                OBS_ADDR: check(e.name, addr, e.val);
                OBS_IRQ:  check(e.name, {15'd0, irq}, e.val);
                default:  check(e.name, {8'h00, tx_data}, e.val);
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [2:0] idx, input logic [15:0] data);
        apb.psel    = 1'b1;
        apb.pwrite  = 1'b1;
        apb.paddr   = {idx, 2'b00};
        apb.pwdata  = data;
        step();
        apb.penable = 1'b1;
        step();
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] idx, input logic [15:0] exp, input string name);
        apb.psel    = 1'b1;
        apb.pwrite  = 1'b0;
        apb.paddr   = {idx, 2'b00};
        step();
        rd_q.push_back('{name, OBS_TX, exp});
        apb.penable = 1'b1;
        step();
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic tx_pop(input logic [7:0] exp, input string name);
        tx_q.push_back('{name, OBS_TX, {8'h00, exp}});
        tx_deq = 1'b1;
        step();
        tx_deq = 1'b0;
    endtask

    task automatic probe(input obs_e sel, input logic [15:0] exp, input string name);
        obs_q.push_back('{name, sel, exp});
        obs_probe = 1'b1;
        step();
        obs_probe = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data = d;
        rx_enq  = 1'b1;
        step();
        rx_enq  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; busy = 1'b0; ctrl_clr = 1'b0; rx_enq = 1'b0; rx_data = '0; tx_deq = 1'b0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state of every register and output
        apb_read(REG_CTRL,     16'h0000, "rst_ctrl");
        apb_read(REG_ADDR,     16'h0000, "rst_addr");
        apb_read(REG_STATUS,   16'h000A, "rst_status");
        apb_read(REG_DATA,     16'h00FF, "rst_data_empty");
        apb_read(REG_RXCNT,    16'h0000, "rst_rxcnt");
        apb_read(REG_TXCNT,    16'h0000, "rst_txcnt");
        apb_read(REG_IRQ_EN,   16'h0000, "rst_irq_en");
        apb_read(REG_IRQ_STAT, 16'h0000, "rst_irq_stat");
        probe(OBS_TX,  16'h00FF, "rst_tx_data");
        probe(OBS_IRQ, 16'h0000, "rst_irq");

        // CTRL/ADDR access and CTRL write beating ctrl_clr
        apb_write(REG_CTRL, 16'h1234);
        apb_write(REG_ADDR, 16'hBEEF);
        apb_read(REG_CTRL, 16'h1234, "ctrl_rw");
        apb_read(REG_ADDR, 16'hBEEF, "addr_rw");
        probe(OBS_ADDR, 16'hBEEF, "addr_port");
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.paddr = {REG_CTRL, 2'b00}; apb.pwdata = 16'h5A5A;
        step();
        apb.penable = 1'b1; ctrl_clr = 1'b1;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; ctrl_clr = 1'b0;
        apb_read(REG_CTRL, 16'h5A5A, "ctrl_write_beats_clr");
        probe(OBS_CTRL, 16'h5A5A, "ctrl_port");
        ctrl_clr = 1'b1;
        step();
        ctrl_clr = 1'b0;
        apb_read(REG_CTRL, 16'h0000, "ctrl_clr");

        // RX fill to full, overflow interrupt, drain
        apb_write(REG_IRQ_EN, 16'h0002);
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'(i);
            rx_enq  = 1'b1;
            step();
        end
        rx_enq = 1'b0;
        apb_read(REG_RXCNT,  16'h0200, "rx_full_cnt");
        apb_read(REG_STATUS, 16'h000C, "rx_full_status");
        rx_push(8'h77);
        probe(OBS_IRQ, 16'h0000, "rx_ovf_irq_n1");
        probe(OBS_IRQ, 16'h0001, "rx_ovf_irq_n2");
        apb_read(REG_IRQ_STAT, 16'h0002, "rx_ovf_stat");
        apb_read(REG_RXCNT,    16'h0200, "rx_ovf_cnt");
        for (int i = 0; i < DEPTH; i++) apb_read(REG_DATA, 16'(i & 8'hFF), "rx_drain");
        apb_read(REG_STATUS, 16'h000A, "rx_drained_status");
        apb_read(REG_RXCNT,  16'h0000, "rx_drained_cnt");
        apb_write(REG_IRQ_STAT, 16'h0002);
        apb_read(REG_IRQ_STAT, 16'h0000, "rx_ovf_w1c");
        probe(OBS_IRQ, 16'h0000, "rx_ovf_irq_clear");

        // TX push, underflow fill and pointer wrap
        apb_write(REG_DATA, 16'h003C);
        apb_read(REG_TXCNT, 16'h0001, "tx_push_cnt");
        probe(OBS_TX, 16'h003C, "tx_head");
        tx_pop(8'h3C, "tx_pop_first");
        tx_pop(8'hFF, "tx_pop_empty_fill");
        apb_read(REG_IRQ_STAT, 16'h0004, "tx_unf_stat");
        apb_read(REG_TXCNT,    16'h0000, "tx_unf_cnt");
        apb_write(REG_IRQ_STAT, 16'h0004);
        for (int j = 0; j < 600; j++) begin
            apb_write(REG_DATA, 16'((j * 7) & 8'hFF));
            tx_pop(8'(j * 7), "tx_wrap");
        end
        apb_read(REG_TXCNT,    16'h0000, "tx_wrap_cnt");
        apb_read(REG_IRQ_STAT, 16'h0000, "tx_wrap_stat");
        apb_write(REG_DATA, 16'h0011);
        apb_write(REG_DATA, 16'h0022);
        apb_read(REG_TXCNT, 16'h0002, "tx_two_cnt");
        apb_write(REG_STATUS, 16'h0002);
        apb_read(REG_TXCNT, 16'h0000, "tx_flush_cnt");
        probe(OBS_TX, 16'h00FF, "tx_flush_head");

        // Simultaneous push/pop on empty, mid-level and full RX
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = {REG_DATA, 2'b00};
        step();
        rd_q.push_back('{"sim_empty_read", OBS_TX, 16'h00FF});
        apb.penable = 1'b1; rx_enq = 1'b1; rx_data = 8'hA1;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; rx_enq = 1'b0;
        apb_read(REG_RXCNT, 16'h0001, "sim_empty_cnt");
        rx_push(8'hA2);
        rx_push(8'hA3);
        apb.psel = 1'b1; apb.paddr = {REG_DATA, 2'b00};
        step();
        rd_q.push_back('{"sim_mid_read", OBS_TX, 16'h00A1});
        apb.penable = 1'b1; rx_enq = 1'b1; rx_data = 8'hA4;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; rx_enq = 1'b0;
        apb_read(REG_RXCNT, 16'h0003, "sim_mid_cnt");
        // Flush beats a same-cycle push
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.paddr = {REG_STATUS, 2'b00}; apb.pwdata = 16'h0001;
        step();
        apb.penable = 1'b1; rx_enq = 1'b1; rx_data = 8'h99;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; rx_enq = 1'b0;
        apb_read(REG_RXCNT, 16'h0000, "rx_flush_beats_push");
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'(i + 16);
            rx_enq  = 1'b1;
            step();
        end
        rx_enq = 1'b0;
        apb.psel = 1'b1; apb.paddr = {REG_DATA, 2'b00};
        step();
        rd_q.push_back('{"sim_full_read", OBS_TX, 16'h0010});
        apb.penable = 1'b1; rx_enq = 1'b1; rx_data = 8'hEE;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; rx_enq = 1'b0;
        apb_read(REG_RXCNT,    16'h0200, "sim_full_cnt");
        apb_read(REG_IRQ_STAT, 16'h0000, "sim_full_no_ovf");
        for (int i = 1; i < DEPTH; i++) apb_read(REG_DATA, 16'((i + 16) & 8'hFF), "full_drain");
        apb_read(REG_DATA,   16'h00EE, "full_freed_slot");
        apb_read(REG_STATUS, 16'h000A, "full_drained_status");

        // Busy falling edge sets done
        apb_write(REG_IRQ_EN, 16'h0001);
        busy = 1'b1;
        step();
        step();
        apb_read(REG_STATUS, 16'h000B, "busy_status");
        busy = 1'b0;
        step();
        step();
        apb_read(REG_IRQ_STAT, 16'h0001, "done_stat");
        probe(OBS_IRQ, 16'h0001, "done_irq");

        // Reset in the middle of traffic
        for (int i = 0; i < 7; i++) rx_push(8'(i + 1));
        apb_read(REG_RXCNT, 16'h0007, "pre_rst_cnt");
        rst = 1'b1;
        step();
        rst = 1'b0;
        apb_read(REG_RXCNT,    16'h0000, "post_rst_rxcnt");
        apb_read(REG_IRQ_STAT, 16'h0000, "post_rst_irq_stat");
        apb_read(REG_DATA,     16'h00FF, "post_rst_data");
        probe(OBS_IRQ, 16'h0000, "post_rst_irq");
        probe(OBS_TX,  16'h00FF, "post_rst_tx");

        repeat (3) step();
        check("scoreboard_drained", 16'(rd_q.size() + tx_q.size() + obs_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
